// File: rtl/opb_register_simulink2ppc_snap.sv
// OPB slave exposing a strobe-captured 32-bit user sample to the PowerPC,
// with new-data flag, saturating overrun counter and freeze/clear control.
module opb_register_simulink2ppc_snap #(
  parameter logic [31:0] C_BASEADDR   = 32'h0100E300,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100E3FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex6"
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst_n,
  input  logic [0:31] OPB_ABus,
  input  logic [0:3]  OPB_BE,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [0:31] Sl_DBus,
  output logic        Sl_xferAck,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  input  logic [31:0] user_data_in,
  input  logic        user_data_valid
);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_e;

  state_e      state_q, state_d;
  logic [31:0] rdata_q;
  logic [2:0]  sel_q;          // {ctrl, status, data}
  logic        rnw_q, be3_q;
  logic [1:0]  wdat_q;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic [7:0]  ovr_q, ovr_d;
  logic        freeze_q, freeze_d;
  logic        clr_q, clr_d;

  // Bus vectors re-indexed so [0] is the LSB.
  logic [31:0] abus, dbus, off, rd_mux;
  logic [2:0]  dec;
  logic        hit, ack, rd_data_clr, rd_stat_clr, ctrl_wr, cap;

  assign abus = OPB_ABus;
  assign dbus = OPB_DBus;
  assign off  = abus - C_BASEADDR;
  assign hit  = OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
  assign dec  = {off == 32'h8, off == 32'h4, off == 32'h0};

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      dec[0]:  rd_mux = data_q;
      dec[1]:  rd_mux = {16'd0, ovr_q, 7'd0, valid_q};
      dec[2]:  rd_mux = {31'd0, freeze_q};
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (hit) state_d = S_ACK;
      S_ACK:   state_d = S_WAIT;
      S_WAIT:  if (!OPB_select) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ack         = (state_q == S_ACK);
  assign rd_data_clr = ack && rnw_q && sel_q[0];
  assign rd_stat_clr = ack && rnw_q && sel_q[1];
  assign ctrl_wr     = ack && !rnw_q && sel_q[2] && be3_q;
  assign cap         = user_data_valid && !freeze_q;

  // Priority: clear > capture > read-side clears.
  always_comb begin
    data_d   = data_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    freeze_d = freeze_q;
    clr_d    = 1'b0;
    if (clr_q) begin
      data_d  = '0;
      valid_d = 1'b0;
      ovr_d   = '0;
    end else begin
      if (rd_data_clr) valid_d = 1'b0;
      if (rd_stat_clr) ovr_d = '0;
      if (cap) begin
        data_d  = user_data_in;
        valid_d = 1'b1;
        if (valid_q)
          ovr_d = rd_stat_clr ? 8'd1 : ((ovr_q == 8'hFF) ? ovr_q : ovr_q + 8'd1);
      end
    end
    if (ctrl_wr) begin
      if (wdat_q[1]) clr_d = 1'b1;
      else           freeze_d = wdat_q[0];
    end
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q  <= S_IDLE;
      rdata_q  <= '0;
      sel_q    <= '0;
      rnw_q    <= 1'b0;
      be3_q    <= 1'b0;
      wdat_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= '0;
      freeze_q <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
      freeze_q <= freeze_d;
      clr_q    <= clr_d;
      if (state_q == S_IDLE && hit) begin
        rdata_q <= rd_mux;
        sel_q   <= dec;
        rnw_q   <= OPB_RNW;
        be3_q   <= OPB_BE[3];
        wdat_q  <= dbus[1:0];
      end
    end
  end

  assign Sl_DBus    = (ack && rnw_q) ? rdata_q : '0;
  assign Sl_xferAck = ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{OPB_seqAddr, OPB_BE[0:2], dbus[31:2], C_OPB_AWIDTH[0],
                       C_OPB_DWIDTH[0], C_FAMILY};

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Randomized + directed bench for the snap register, against a sample/flag/counter model.
module tb_opb_register_simulink2ppc_snap;

  localparam logic [31:0] BASE = 32'h0100E300;
  localparam logic [31:0] HIGH = 32'h0100E3FF;

  logic        clk = 0, rst_n = 0;
  logic [0:31] abus = '0, dbus = '0, sl_dbus;
  logic [0:3]  be = '0;
  logic        rnw = 0, sel = 0, seqa = 0;
  logic        ack, errack, retry, toutsup;
  logic [31:0] udin = '0;
  logic        udv = 0;

  opb_register_simulink2ppc_snap dut (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seqa), .Sl_DBus(sl_dbus),
    .Sl_xferAck(ack), .Sl_errAck(errack), .Sl_retry(retry), .Sl_toutSup(toutsup),
    .user_data_in(udin), .user_data_valid(udv)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  bit rnd_stb = 0;

  // Reference model state
  logic [31:0] m_data;
  bit          m_valid, m_freeze, m_clr;
  int          m_ovr;
  bit          f_rd_data, f_rd_stat, f_wr, f_be3;
  logic [31:0] f_wdat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_data = 0; m_valid = 0; m_freeze = 0; m_clr = 0; m_ovr = 0;
  endfunction

  function automatic void model_step();
    bit nclr = 0;
    bit was = m_valid;
    int o = m_ovr;
    if (m_clr) begin
      m_data = 0; m_valid = 0; m_ovr = 0;
    end else begin
      if (f_rd_data) m_valid = 0;
      if (f_rd_stat) m_ovr = 0;
      if (udv && !m_freeze) begin
        m_data = udin; m_valid = 1;
        if (was) m_ovr = f_rd_stat ? 1 : ((o < 255) ? o + 1 : 255);
      end
    end
    if (f_wr && f_be3) begin
      if (f_wdat[1]) nclr = 1;
      else m_freeze = f_wdat[0];
    end
    m_clr = nclr;
  endfunction

  function automatic logic [31:0] mreg(input logic [31:0] a);
    logic [31:0] o = a - BASE;
    logic [7:0]  ov = 8'(m_ovr);
    if (a < BASE || a > HIGH) return 0;
    case (o)
      32'h0:   return m_data;
      32'h4:   return {16'd0, ov, 7'd0, m_valid};
      32'h8:   return {31'd0, m_freeze};
      default: return 0;
    endcase
  endfunction

  task automatic tick();
    if (rnd_stb) begin
      udv  = ($urandom_range(0, 2) == 0);
      udin = $urandom;
    end
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    @(negedge clk);
  endtask

  // One full transfer: select in cycle N, ack expected in N+1, select dropped in N+2.
  task automatic xfer(input string tag, input logic [31:0] addr, input bit rd,
                      input logic [31:0] wd, input logic [3:0] b, input bit sa,
                      input logic [31:0] sv, output logic [31:0] got);
    logic [31:0] exp = mreg(addr);
    logic [31:0] o   = addr - BASE;
    abus = addr; rnw = rd; dbus = wd; be = b; sel = 1;
    chk({tag, "_preack"}, {31'd0, ack}, 0);
    tick();
    if (!rnd_stb) begin udv = sa; udin = sv; end
    got = sl_dbus;
    chk({tag, "_ack"}, {31'd0, ack}, 1);
    chk({tag, "_dbus"}, got, rd ? exp : 32'd0);
    f_rd_data = rd && o == 0; f_rd_stat = rd && o == 4; f_wr = !rd && o == 8;
    f_wdat = wd; f_be3 = b[0];
    tick();
    f_rd_data = 0; f_rd_stat = 0; f_wr = 0;
    if (!rnd_stb) udv = 0;
    sel = 0;
    chk({tag, "_oneack"}, {31'd0, ack}, 0);
    chk({tag, "_dbus0"}, sl_dbus, 0);
    tick();
  endtask

  task automatic rd(input string tag, input logic [31:0] o, output logic [31:0] got);
    xfer(tag, BASE + o, 1, 0, 4'b1111, 0, 0, got);
  endtask

  task automatic wr(input string tag, input logic [31:0] o, input logic [31:0] wd,
                    input logic [3:0] b);
    logic [31:0] g;
    xfer(tag, BASE + o, 0, wd, b, 0, 0, g);
  endtask

  task automatic strobe(input logic [31:0] v);
    udv = 1; udin = v; tick(); udv = 0;
  endtask

  // Hold select for several cycles; count acks and require Sl_DBus = 0 throughout.
  task automatic hold(input string tag, input logic [31:0] addr, input int exp_acks);
    int acks = 0;
    abus = addr; rnw = 1; be = 4'b1111; sel = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      acks += ack;
      chk({tag, "_dbus"}, sl_dbus, 0);
    end
    sel = 0;
    tick(); tick();
    chk({tag, "_acks"}, acks, exp_acks);
  endtask

  logic [31:0] g, old;

  initial begin
    model_reset();
    f_rd_data = 0; f_rd_stat = 0; f_wr = 0; f_be3 = 0; f_wdat = 0;
    repeat (3) tick();
    chk("rst_ack", {31'd0, ack}, 0);
    chk("rst_dbus", sl_dbus, 0);
    chk("rst_ties", {29'd0, errack, retry, toutsup}, 0);
    rst_n = 1;
    tick();

    // Basic capture and read-clear of valid
    strobe(32'hDEADBEEF);
    rd("t2_data", 0, g);    chk("t2_data_val", g, 32'hDEADBEEF);
    rd("t2_stat", 4, g);    chk("t2_stat_val", g, 32'h0);

    // Overrun counting and saturation
    for (int i = 0; i < 3; i++) strobe(32'h100 + i);
    rd("t3_stat3", 4, g);   chk("t3_stat3_val", g, 32'h00000201);
    for (int i = 0; i < 300; i++) strobe(i);
    rd("t3_stat300", 4, g); chk("t3_stat300_val", g, 32'h0000FF01);

    // Freeze blocks capture; clear zeroes sample, flag and counter
    rd("t4_pre", 0, old);
    wr("t4_frz", 8, 32'h1, 4'b0001);
    strobe(32'h12345678);
    rd("t4_data", 0, g);    chk("t4_data_frozen", g, old);
    rd("t4_stat", 4, g);    chk("t4_stat_frozen", g, 32'h0);
    wr("t4_clr", 8, 32'h2, 4'b0001);
    repeat (2) tick();
    rd("t4_data0", 0, g);   chk("t4_data_clr", g, 32'h0);
    rd("t4_stat0", 4, g);   chk("t4_stat_clr", g, 32'h0);
    rd("t4_ctrl", 8, g);    chk("t4_ctrl_val", g, 32'h1);
    wr("t4_nobe", 8, 32'h0, 4'b1110);
    rd("t4_ctrl_nobe", 8, g); chk("t4_ctrl_nobe_val", g, 32'h1);
    wr("t4_unfrz", 8, 32'h0, 4'b0001);
    rd("t4_ctrl0", 8, g);   chk("t4_ctrl0_val", g, 32'h0);

    // Capture in the same cycle as a DATA-read ack
    strobe(32'h11111111);
    xfer("t5_race", BASE, 1, 0, 4'b1111, 1, 32'hAAAA5555, g);
    chk("t5_old", g, 32'h11111111);
    rd("t5_stat", 4, g);
    rd("t5_data", 0, g);    chk("t5_new", g, 32'hAAAA5555);

    // Held select, unmapped offset and out-of-window address
    hold("t6_hold", BASE + 32'hF0, 1);
    hold("t6_oow", 32'h0100E400, 0);
    wr("t6_wunmap", 32'hC, 32'hFFFFFFFF, 4'b1111);

    // Random traffic with random strobes every cycle
    rnd_stb = 1;
    for (int i = 0; i < 250; i++) begin
      logic [31:0] offs [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h40};
      logic [31:0] o = offs[$urandom_range(0, 4)];
      logic [31:0] wd = (($urandom_range(0, 3) == 0) ? 32'h2 : 32'h0) |
                        {31'd0, ($urandom_range(0, 3) == 0)} | ($urandom & 32'hFFFFFFFC);
      if ($urandom_range(0, 2) == 0)
        xfer("rnd_wr", BASE + o, 0, wd, 4'($urandom), 0, 0, g);
      else
        xfer("rnd_rd", BASE + o, 1, 0, 4'b1111, 0, 0, g);
      repeat ($urandom_range(0, 3)) tick();
    end

    // Reset in the middle of an acked transfer
    abus = BASE; rnw = 1; be = 4'b1111; sel = 1;
    tick();
    rst_n = 0;
    #1;
    chk("t1_ack", {31'd0, ack}, 0);
    chk("t1_dbus", sl_dbus, 0);
    chk("t1_ties", {29'd0, errack, retry, toutsup}, 0);
    sel = 0; rnd_stb = 0; udv = 0;
    tick(); tick();
    rst_n = 1;
    tick();
    rd("t1_data", 0, g);    chk("t1_data0", g, 32'h0);
    rd("t1_stat", 4, g);    chk("t1_stat0", g, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
